audio_out_mixer_sched: RTL and testbench
========================================

# audio_out_mixer_sched

Scheduler/mixer that owns the audio controller's output-FIFO write port and shares it among up to NUM_SRC sample producers (microphone passthrough, tone generator, effects). Once per output frame it polls each enabled source in a fixed order, accepts one stereo sample per source over a valid/ready handshake, and sums the samples with signed saturation. When the controller reports `audio_out_allowed`, it issues exactly one `write_audio_out` pulse. It sits between the sound sources and the audio controller, replacing ad-hoc `in + tone` addition with a sequenced, fair path.

## Interface
- NUM_SRC, 4, number of sample sources (1..8)
- SAMPLE_W, 32, signed sample width per channel
- WAIT_MAX, 255, cycles to wait on a non-valid enabled source before skipping it
- CLOCK_50  in  1  system clock; all logic on its rising edge
- reset_n  in  1  synchronous, active-low reset
- src_enable  in  NUM_SRC  per-source mix enable (e.g. from SW); sampled at frame start
- src_valid  in  NUM_SRC  source i has a sample on its data lanes
- src_left  in  NUM_SRC*SAMPLE_W  left samples; lane i at [i*SAMPLE_W +: SAMPLE_W]
- src_right  in  NUM_SRC*SAMPLE_W  right samples, same packing
- src_ready  out  NUM_SRC  one-hot; sample accepted when src_valid[i] & src_ready[i]
- audio_out_allowed  in  1  controller output FIFO has space
- write_audio_out  out  1  single-cycle write strobe to controller
- left_channel_audio_out  out  SAMPLE_W  mixed left sample, registered
- right_channel_audio_out  out  SAMPLE_W  mixed right sample, registered
- underrun_count  out  16  saturating count of timed-out source slots
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, SCAN, WAIT_OUT, WRITE.
- IDLE: entered on reset. Moves to SCAN on the next cycle. On entry to SCAN, `src_enable` is latched into `en_q`, `idx` is cleared to 0, both accumulators are cleared to 0, and the wait counter is cleared to 0.
- SCAN, source `idx`:
  - en_q[idx]=0: skip in 1 cycle; `src_ready` stays all-zero.
  - en_q[idx]=1: `src_ready[idx]` is high combinationally while in this slot.
    - src_valid[idx]=1: add the sign-extended samples to the accumulators, then advance.
    - src_valid[idx]=0: increment the wait counter. When it reaches WAIT_MAX, skip the slot, increment `underrun_count` (saturates at 16'hFFFF), and advance.
  - Advancing: `idx`+1 and the wait counter cleared. After idx=NUM_SRC-1, go to WAIT_OUT.
- Accumulators are SAMPLE_W+3 bits signed. At the SCAN→WAIT_OUT transition, each channel is saturated to SAMPLE_W signed range (max 2^(SAMPLE_W-1)-1, min -2^(SAMPLE_W-1)) and registered into the output port.
- All sources disabled or all timed out: a zero sample is still written, so the DAC is never starved.
- WAIT_OUT: holds while `audio_out_allowed`=0. When it is 1, go to WRITE.
- WRITE: `write_audio_out`=1 for exactly this cycle, with data stable. Next state is SCAN (new frame; enables re-latched).
- `src_enable` changes mid-frame take effect at the next frame only.
- Reset mid-frame: any in-progress frame is discarded and no write is issued.

## Timing
- Reset values:
  - state IDLE
  - src_ready=0, write_audio_out=0
  - left/right outputs=0
  - underrun_count=0, busy=0
- Handshake: a source may assert valid at any time and must hold its data until it sees ready. Ready is never high for more than one index at a time.
- Per-slot cost: 1 cycle if the source is disabled or already valid; k+1 cycles if valid arrives k cycles late; WAIT_MAX cycles on timeout.
- Minimum frame with all enabled sources valid: NUM_SRC (SCAN) + 1 (WAIT_OUT, allowed already high) + 1 (WRITE) = NUM_SRC+2 cycles. That is 6 cycles at the defaults, far below the 48 kHz frame period.
- Output data updates only at the SCAN→WAIT_OUT edge and stays stable through WRITE.
- `busy` deasserts only in IDLE, i.e. for one cycle after reset release.

## Test plan
- Basic mix: NUM_SRC=4, all enabled and valid; L samples 100, 200, -50, 0 and R = -L. Required: one write with L=250, R=-250; src_ready pulses idx 0..3 on consecutive cycles; write occurs 6 cycles after the frame starts.
- Saturation: two sources at L=32'h7FFF_FFFF and 32'h0000_0010, R=32'h8000_0000 twice. Required: L=32'h7FFF_FFFF, R=32'h8000_0000.
- Timeout: source 2 enabled but never valid, WAIT_MAX=255. Required: underrun_count increments by 1; frame length = 3 + 255 + 2 cycles; mix excludes source 2.
- Backpressure: audio_out_allowed held 0 for 40 cycles after SCAN completes. Required: write_audio_out stays 0 and data stays stable; exactly one pulse in the cycle after allowed rises.
- Enables: src_enable=0. Required: zero sample written every NUM_SRC+2 cycles and src_ready never asserted. Then set enable bit 1 mid-SCAN: source 1 is mixed starting the next frame only.
- Reset mid-frame: drive reset_n low during SCAN idx=2 for one cycle. Required: no write that frame; all outputs return to reset values; the next frame starts from idx 0.

Source files
------------

// File: rtl/audio_out_mixer_sched.sv
// Output-FIFO write scheduler: polls enabled sample sources once per frame,
// mixes their stereo samples with signed saturation and issues one write per frame.
module audio_out_mixer_sched #(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned SAMPLE_W = 32,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic                         CLOCK_50,
    input  logic                         reset_n,
    input  logic [NUM_SRC-1:0]           src_enable,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*SAMPLE_W-1:0]  src_left,
    input  logic [NUM_SRC*SAMPLE_W-1:0]  src_right,
    output logic [NUM_SRC-1:0]           src_ready,
    input  logic                         audio_out_allowed,
    output logic                         write_audio_out,
    output logic [SAMPLE_W-1:0]          left_channel_audio_out,
    output logic [SAMPLE_W-1:0]          right_channel_audio_out,
    output logic [15:0]                  underrun_count,
    output logic                         busy
);

    localparam int unsigned IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);
    localparam int unsigned ACC_W  = SAMPLE_W + 3;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SRC - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT_OUT, WRITE} state_t;

    // Clamp the wide accumulator into the SAMPLE_W signed range.
    function automatic logic [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
        if (a[ACC_W-1:SAMPLE_W-1] == {(ACC_W-SAMPLE_W+1){a[ACC_W-1]}})
            return a[SAMPLE_W-1:0];
        else if (a[ACC_W-1])
            return {1'b1, {(SAMPLE_W-1){1'b0}}};
        else
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
    endfunction

    state_t                    state_q, state_d;
    logic [NUM_SRC-1:0]        en_q, en_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [WAIT_W-1:0]         wait_q, wait_d;
    logic signed [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [SAMPLE_W-1:0]       left_d, right_d;
    logic [15:0]               under_d;
    logic [NUM_SRC-1:0]        ready_d;
    logic                      write_d, busy_d, advance;
    logic signed [SAMPLE_W-1:0] lane_l, lane_r;

    assign lane_l = src_left[idx_q*SAMPLE_W +: SAMPLE_W];
    assign lane_r = src_right[idx_q*SAMPLE_W +: SAMPLE_W];

    // Next-state, datapath and (pre-registered) output decode.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        left_d  = left_channel_audio_out;
        right_d = right_channel_audio_out;
        under_d = underrun_count;
        advance = 1'b0;
        ready_d = '0;

        case (state_q)
            IDLE: state_d = SCAN;
            SCAN: begin
                if (!en_q[idx_q]) begin
                    advance = 1'b1;
                end else if (src_valid[idx_q]) begin
                    acc_l_d = acc_l_q + ACC_W'(lane_l);
                    acc_r_d = acc_r_q + ACC_W'(lane_r);
                    advance = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    advance = 1'b1;
                    if (underrun_count != 16'hFFFF) under_d = underrun_count + 16'd1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
                if (advance) begin
                    wait_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = WAIT_OUT;
                        left_d  = saturate(acc_l_d);
                        right_d = saturate(acc_r_d);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            WAIT_OUT: if (audio_out_allowed) state_d = WRITE;
            WRITE:    state_d = SCAN;
            default:  state_d = IDLE;
        endcase

        // Frame start: enables are captured here and only here.
        if (state_d == SCAN && state_q != SCAN) begin
            en_d    = src_enable;
            idx_d   = '0;
            wait_d  = '0;
            acc_l_d = '0;
            acc_r_d = '0;
        end

        if (state_d == SCAN && en_d[idx_d]) ready_d[idx_d] = 1'b1;
        write_d = (state_d == WRITE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q                 <= IDLE;
            en_q                    <= '0;
            idx_q                   <= '0;
            wait_q                  <= '0;
            acc_l_q                 <= '0;
            acc_r_q                 <= '0;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
            underrun_count          <= '0;
            src_ready               <= '0;
            write_audio_out         <= 1'b0;
            busy                    <= 1'b0;
        end else begin
            state_q                 <= state_d;
            en_q                    <= en_d;
            idx_q                   <= idx_d;
            wait_q                  <= wait_d;
            acc_l_q                 <= acc_l_d;
            acc_r_q                 <= acc_r_d;
            left_channel_audio_out  <= left_d;
            right_channel_audio_out <= right_d;
            underrun_count          <= under_d;
            src_ready               <= ready_d;
            write_audio_out         <= write_d;
            busy                    <= busy_d;
        end
    end

endmodule

// File: tb/tb_audio_out_mixer_sched.sv
// Bench for audio_out_mixer_sched: directed and random frames against a
// slot-cost / saturating-sum model of one output frame.
module tb_audio_out_mixer_sched;

    localparam int NS = 4;
    localparam int SW = 32;
    localparam int WM = 255;
    localparam int NEVER = 1000000;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NS-1:0]       src_enable, src_valid, src_ready;
    logic [NS*SW-1:0]    src_left, src_right;
    logic                audio_out_allowed, write_audio_out, busy;
    logic [SW-1:0]       left_out, right_out;
    logic [15:0]         underrun_count;

    always #5 clk = ~clk;

    audio_out_mixer_sched #(.NUM_SRC(NS), .SAMPLE_W(SW), .WAIT_MAX(WM)) dut (
        .CLOCK_50(clk), .reset_n(reset_n),
        .src_enable(src_enable), .src_valid(src_valid),
        .src_left(src_left), .src_right(src_right), .src_ready(src_ready),
        .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
        .left_channel_audio_out(left_out), .right_channel_audio_out(right_out),
        .underrun_count(underrun_count), .busy(busy)
    );

    int total = 0;
    int bad = 0;

    // Per-frame stimulus description, set before each run_frame call.
    int           arr[NS];
    logic [SW-1:0] dl[NS];
    logic [SW-1:0] dr[NS];
    int           bp = 0;
    logic [NS-1:0] cur_en;
    logic [SW-1:0] prev_l = '0, prev_r = '0;
    int           exp_under = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] clamp(input longint s);
        if (s > 64'sd2147483647)       return 32'h7FFF_FFFF;
        else if (s < -64'sd2147483648) return 32'h8000_0000;
        else                           return SW'(s);
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 64'(src_ready), 64'(0));
        chk({tag, "_write"}, 64'(write_audio_out), 64'(0));
        chk({tag, "_left"}, 64'(left_out), 64'(0));
        chk({tag, "_right"}, 64'(right_out), 64'(0));
        chk({tag, "_under"}, 64'(underrun_count), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic drive_lanes(input int rel);
        for (int i = 0; i < NS; i++) begin
            src_valid[i] = (rel >= arr[i]);
            src_left[i*SW +: SW] = dl[i];
            src_right[i*SW +: SW] = dr[i];
        end
    endtask

    // One frame starting now (DUT just entered SCAN). nxt is driven onto
    // src_enable at cycle chg (or the write cycle if chg < 0).
    task automatic run_frame(input string tag, input logic [NS-1:0] nxt, input int chg);
        int st[NS];
        int cs[NS];
        int t = 0;
        int nto = 0;
        int s_len, last;
        longint sl = 0, sr = 0;
        logic [SW-1:0] el, er;
        logic [NS-1:0] exp_rdy;
        for (int i = 0; i < NS; i++) begin
            st[i] = t;
            if (!cur_en[i]) cs[i] = 1;
            else if (arr[i] <= t) begin
                cs[i] = 1;
                sl += longint'($signed(dl[i]));
                sr += longint'($signed(dr[i]));
            end else if (arr[i] - t < WM) begin
                cs[i] = arr[i] - t + 1;
                sl += longint'($signed(dl[i]));
                sr += longint'($signed(dr[i]));
            end else begin
                cs[i] = WM;
                nto++;
            end
            t += cs[i];
        end
        s_len = t;
        last = s_len + bp + 1;
        el = clamp(sl);
        er = clamp(sr);
        exp_under = (exp_under + nto > 65535) ? 65535 : exp_under + nto;
        for (int rel = 0; rel <= last; rel++) begin
            drive_lanes(rel);
            audio_out_allowed = (rel >= s_len + bp);
            if (rel == chg || (chg < 0 && rel == last)) src_enable = nxt;
            exp_rdy = '0;
            for (int i = 0; i < NS; i++)
                if (cur_en[i] && rel >= st[i] && rel < st[i] + cs[i]) exp_rdy[i] = 1'b1;
            chk({tag, "_ready"}, 64'(src_ready), 64'(exp_rdy));
            chk({tag, "_write"}, 64'(write_audio_out), 64'(rel == last));
            chk({tag, "_busy"}, 64'(busy), 64'(1));
            chk({tag, "_left"}, 64'(left_out), 64'((rel >= s_len) ? el : prev_l));
            chk({tag, "_right"}, 64'(right_out), 64'((rel >= s_len) ? er : prev_r));
            if (rel == last) chk({tag, "_under"}, 64'(underrun_count), 64'(exp_under));
            tick();
        end
        prev_l = el;
        prev_r = er;
        cur_en = nxt;
    endtask

    task automatic set_all_valid_now;
        for (int i = 0; i < NS; i++) arr[i] = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        src_enable = 4'hF;
        src_valid = '0;
        src_left = '0;
        src_right = '0;
        audio_out_allowed = 1'b0;
        cur_en = 4'hF;
        tick();
        check_reset("reset");
        tick();
        tick();
        reset_n = 1'b1;
        chk("idle_busy", 64'(busy), 64'(0));
        tick();

        // Basic mix
        set_all_valid_now();
        dl[0] = 32'd100;  dl[1] = 32'd200;  dl[2] = -32'sd50; dl[3] = 32'd0;
        for (int i = 0; i < NS; i++) dr[i] = -dl[i];
        run_frame("basic", 4'b0011, -1);

        // Saturation, sources 0 and 1 only
        dl[0] = 32'h7FFF_FFFF; dl[1] = 32'h0000_0010; dl[2] = 32'h1234; dl[3] = 32'h5678;
        dr[0] = 32'h8000_0000; dr[1] = 32'h8000_0000; dr[2] = 32'h1; dr[3] = 32'h2;
        run_frame("sat", 4'hF, -1);

        // Timeout on source 2
        dl[0] = 32'd7; dl[1] = 32'd11; dl[2] = 32'd1000; dl[3] = -32'sd3;
        dr[0] = -32'sd7; dr[1] = 32'd5; dr[2] = 32'd1000; dr[3] = 32'd9;
        arr[2] = NEVER;
        run_frame("timeout", 4'hF, -1);

        // Late sources plus backpressure
        set_all_valid_now();
        arr[1] = 3;
        arr[3] = 9;
        bp = 40;
        run_frame("backpr", 4'h0, -1);
        bp = 0;

        // Enables off, then bit 1 set mid-scan
        set_all_valid_now();
        run_frame("en_off", 4'h0, -1);
        run_frame("en_mid", 4'b0010, 2);
        run_frame("en_src1", 4'hF, -1);

        // Reset mid-frame during slot 2
        for (int i = 0; i < NS; i++) begin
            dl[i] = $urandom();
            dr[i] = $urandom();
        end
        audio_out_allowed = 1'b1;
        for (int rel = 0; rel <= 2; rel++) begin
            drive_lanes(rel);
            chk("rstmid_ready", 64'(src_ready), 64'(1 << rel));
            chk("rstmid_write", 64'(write_audio_out), 64'(0));
            if (rel == 2) reset_n = 1'b0;
            tick();
        end
        check_reset("rstmid");
        reset_n = 1'b1;
        exp_under = 0;
        prev_l = '0;
        prev_r = '0;
        tick();
        run_frame("after_rst", 4'hF, -1);

        // Random frames
        for (int f = 0; f < 30; f++) begin
            int sel;
            int chg;
            for (int i = 0; i < NS; i++) begin
                sel = int'($urandom_range(0, 19));
                if (sel < 12)      arr[i] = int'($urandom_range(0, 4));
                else if (sel < 16) arr[i] = int'($urandom_range(0, 12));
                else if (sel < 18) arr[i] = 250 + int'($urandom_range(0, 10));
                else               arr[i] = NEVER;
                if ($urandom_range(0, 1) == 0) begin
                    dl[i] = $urandom();
                    dr[i] = $urandom();
                end else begin
                    dl[i] = SW'(int'($urandom_range(0, 2000)) - 1000);
                    dr[i] = SW'(int'($urandom_range(0, 2000)) - 1000);
                end
            end
            bp = int'($urandom_range(0, 3));
            chg = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 5));
            run_frame("rand", NS'($urandom()), chg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
